id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register sitting directly downstream of the register file and decode logic.
- Captures operand values and decoded control each cycle and presents them to the execute stage.
- Supports freeze (hazard stall) and flush (taken branch), and inserts bubbles on flush.
- Bypasses same-cycle and held-entry writeback results so captured operands are never stale.

---
 rtl/arm_pkg.sv | 18 +
 rtl/wb_bypass_mux.sv | 22 ++
 rtl/id_ex_stage_reg.sv | 138 +++++++++++++
 tb/tb_id_ex_stage_reg.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared constants and the decoded control bundle carried through the ID/EX stage.
package arm_pkg;

  localparam logic [3:0] REG_PC    = 4'd15;
  localparam int         EXE_CMD_W = 4;
  localparam int         STATUS_W  = 4;

  typedef struct packed {
    logic [EXE_CMD_W-1:0] exe_cmd;
    logic                 mem_r_en;
    logic                 mem_w_en;
    logic                 wb_en;
    logic                 b;
    logic                 s;
    logic                 imm;
  } ctrl_t;

endpackage

// File: rtl/wb_bypass_mux.sv
// Selects the writeback result over a register value when writeback targets that register.
module wb_bypass_mux
  import arm_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic [DW-1:0] value_in,
  input  logic [AW-1:0] addr,
  input  logic          wb_en_wb,
  input  logic [AW-1:0] dest_wb,
  input  logic [DW-1:0] result_wb,
  output logic [DW-1:0] value_out
);

  logic hit;

  // The PC is never forwarded from writeback.
  assign hit       = wb_en_wb && (dest_wb != AW'(REG_PC)) && (dest_wb == addr);
  assign value_out = hit ? result_wb : value_in;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with freeze, flush-to-bubble, writeback bypass and a stall counter.
module id_ex_stage_reg
  import arm_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic                 valid_in,
  input  logic [DW-1:0]        pc_in,
  input  logic [DW-1:0]        val_rn_in,
  input  logic [DW-1:0]        val_rm_in,
  input  logic [AW-1:0]        src1_in,
  input  logic [AW-1:0]        src2_in,
  input  logic [AW-1:0]        dest_in,
  input  logic [EXE_CMD_W-1:0] exe_cmd_in,
  input  logic                 mem_r_en_in,
  input  logic                 mem_w_en_in,
  input  logic                 wb_en_in,
  input  logic                 b_in,
  input  logic                 s_in,
  input  logic                 imm_in,
  input  logic [11:0]          shift_operand_in,
  input  logic [23:0]          signed_imm24_in,
  input  logic [STATUS_W-1:0]  status_in,
  input  logic                 wb_en_wb,
  input  logic [AW-1:0]        dest_wb,
  input  logic [DW-1:0]        result_wb,
  output logic                 valid_out,
  output logic [DW-1:0]        pc_out,
  output logic [DW-1:0]        val_rn_out,
  output logic [DW-1:0]        val_rm_out,
  output logic [AW-1:0]        src1_out,
  output logic [AW-1:0]        src2_out,
  output logic [AW-1:0]        dest_out,
  output logic [EXE_CMD_W-1:0] exe_cmd_out,
  output logic                 mem_r_en_out,
  output logic                 mem_w_en_out,
  output logic                 wb_en_out,
  output logic                 b_out,
  output logic                 s_out,
  output logic                 imm_out,
  output logic [11:0]          shift_operand_out,
  output logic [23:0]          signed_imm24_out,
  output logic [STATUS_W-1:0]  status_out,
  output logic [CW-1:0]        stall_cnt
);

  ctrl_t         ctrl_in;
  ctrl_t         ctrl_q;
  logic [DW-1:0] rn_base, rm_base, rn_sel, rm_sel;
  logic [AW-1:0] rn_addr, rm_addr;

  assign ctrl_in = '{exe_cmd: exe_cmd_in, mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in,
                     wb_en: wb_en_in, b: b_in, s: s_in, imm: imm_in};

  // One mux pair serves both cases: held entry while frozen, incoming operands otherwise.
  assign rn_base = freeze ? val_rn_out : val_rn_in;
  assign rm_base = freeze ? val_rm_out : val_rm_in;
  assign rn_addr = freeze ? src1_out   : src1_in;
  assign rm_addr = freeze ? src2_out   : src2_in;

  wb_bypass_mux #(.DW(DW), .AW(AW)) u_rn_byp (
    .value_in  (rn_base),
    .addr      (rn_addr),
    .wb_en_wb  (wb_en_wb),
    .dest_wb   (dest_wb),
    .result_wb (result_wb),
    .value_out (rn_sel)
  );

  wb_bypass_mux #(.DW(DW), .AW(AW)) u_rm_byp (
    .value_in  (rm_base),
    .addr      (rm_addr),
    .wb_en_wb  (wb_en_wb),
    .dest_wb   (dest_wb),
    .result_wb (result_wb),
    .value_out (rm_sel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out         <= 1'b0;
      pc_out            <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      dest_out          <= '0;
      ctrl_q            <= '0;
      shift_operand_out <= '0;
      signed_imm24_out  <= '0;
      status_out        <= '0;
      stall_cnt         <= '0;
    end else if (flush) begin
      valid_out         <= 1'b0;
      pc_out            <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      dest_out          <= '0;
      ctrl_q            <= '0;
      shift_operand_out <= '0;
      signed_imm24_out  <= '0;
      status_out        <= '0;
    end else if (freeze) begin
      val_rn_out <= rn_sel;
      val_rm_out <= rm_sel;
      if (stall_cnt != '1) stall_cnt <= stall_cnt + CW'(1);
    end else begin
      valid_out         <= valid_in;
      pc_out            <= pc_in;
      val_rn_out        <= rn_sel;
      val_rm_out        <= rm_sel;
      src1_out          <= src1_in;
      src2_out          <= src2_in;
      dest_out          <= dest_in;
      ctrl_q            <= ctrl_in;
      shift_operand_out <= shift_operand_in;
      signed_imm24_out  <= signed_imm24_in;
      status_out        <= status_in;
    end
  end

  assign exe_cmd_out  = ctrl_q.exe_cmd;
  assign mem_r_en_out = ctrl_q.mem_r_en;
  assign mem_w_en_out = ctrl_q.mem_w_en;
  assign wb_en_out    = ctrl_q.wb_en;
  assign b_out        = ctrl_q.b;
  assign s_out        = ctrl_q.s;
  assign imm_out      = ctrl_q.imm;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed vector table, corner sequences, randomized model comparison.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rn, rm;
    logic [3:0]  s1, s2, d, cmd;
    logic        mr, mw, wb, b, s, imm;
    logic [11:0] sh;
    logic [23:0] off;
    logic [3:0]  st;
  } fields_t;

  typedef struct {
    fields_t     in;
    logic        wbe;
    logic [3:0]  dwb;
    logic [31:0] rwb;
    logic [31:0] exp_rn, exp_rm;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0, flush = 1'b0, wbe = 1'b0;
  logic [3:0]  dwb = '0;
  logic [31:0] rwb = '0;
  fields_t     in_f = '0;
  fields_t     exp_f = '0;
  fields_t     out_f;
  int          checks = 0, errors = 0;
  int          exp_cnt = 0, exp_cnt4 = 0;

  always #5 clk = ~clk;

  logic        valid_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, imm_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [3:0]  src1_out, src2_out, dest_out, exe_cmd_out, status_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic [15:0] stall_cnt;

  logic        x_valid, x_mr, x_mw, x_wb, x_b, x_s, x_imm;
  logic [31:0] x_pc, x_rn, x_rm;
  logic [3:0]  x_s1, x_s2, x_d, x_cmd, x_st;
  logic [11:0] x_sh;
  logic [23:0] x_off;
  logic [3:0]  cnt4;

  id_ex_stage_reg #(.DW(32), .AW(4), .CW(16)) u_dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(in_f.valid),
    .pc_in(in_f.pc), .val_rn_in(in_f.rn), .val_rm_in(in_f.rm),
    .src1_in(in_f.s1), .src2_in(in_f.s2), .dest_in(in_f.d), .exe_cmd_in(in_f.cmd),
    .mem_r_en_in(in_f.mr), .mem_w_en_in(in_f.mw), .wb_en_in(in_f.wb), .b_in(in_f.b),
    .s_in(in_f.s), .imm_in(in_f.imm), .shift_operand_in(in_f.sh),
    .signed_imm24_in(in_f.off), .status_in(in_f.st),
    .wb_en_wb(wbe), .dest_wb(dwb), .result_wb(rwb),
    .valid_out(valid_out), .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .src1_out(src1_out), .src2_out(src2_out), .dest_out(dest_out), .exe_cmd_out(exe_cmd_out),
    .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out), .wb_en_out(wb_en_out),
    .b_out(b_out), .s_out(s_out), .imm_out(imm_out), .shift_operand_out(shift_operand_out),
    .signed_imm24_out(signed_imm24_out), .status_out(status_out), .stall_cnt(stall_cnt)
  );

  id_ex_stage_reg #(.DW(32), .AW(4), .CW(4)) u_dut4 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(in_f.valid),
    .pc_in(in_f.pc), .val_rn_in(in_f.rn), .val_rm_in(in_f.rm),
    .src1_in(in_f.s1), .src2_in(in_f.s2), .dest_in(in_f.d), .exe_cmd_in(in_f.cmd),
    .mem_r_en_in(in_f.mr), .mem_w_en_in(in_f.mw), .wb_en_in(in_f.wb), .b_in(in_f.b),
    .s_in(in_f.s), .imm_in(in_f.imm), .shift_operand_in(in_f.sh),
    .signed_imm24_in(in_f.off), .status_in(in_f.st),
    .wb_en_wb(wbe), .dest_wb(dwb), .result_wb(rwb),
    .valid_out(x_valid), .pc_out(x_pc), .val_rn_out(x_rn), .val_rm_out(x_rm),
    .src1_out(x_s1), .src2_out(x_s2), .dest_out(x_d), .exe_cmd_out(x_cmd),
    .mem_r_en_out(x_mr), .mem_w_en_out(x_mw), .wb_en_out(x_wb),
    .b_out(x_b), .s_out(x_s), .imm_out(x_imm), .shift_operand_out(x_sh),
    .signed_imm24_out(x_off), .status_out(x_st), .stall_cnt(cnt4)
  );

  assign out_f = '{valid: valid_out, pc: pc_out, rn: val_rn_out, rm: val_rm_out,
                   s1: src1_out, s2: src2_out, d: dest_out, cmd: exe_cmd_out,
                   mr: mem_r_en_out, mw: mem_w_en_out, wb: wb_en_out, b: b_out,
                   s: s_out, imm: imm_out, sh: shift_operand_out,
                   off: signed_imm24_out, st: status_out};

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, expv);
    end
  endtask

  task automatic compare_all(input string name);
    chk(name, 192'(out_f), 192'(exp_f));
    chk({name, "_cnt"}, 192'(stall_cnt), 192'(exp_cnt));
    chk({name, "_cnt4"}, 192'(cnt4), 192'(exp_cnt4));
  endtask

  function automatic bit byp(input logic [3:0] a);
    return wbe && (dwb != 4'd15) && (dwb == a);
  endfunction

  // Next held entry from the behavioural rules: flush > freeze > load.
  task automatic model_step();
    if (flush) begin
      exp_f = '0;
    end else if (freeze) begin
      exp_cnt  = (exp_cnt  == 65535) ? 65535 : exp_cnt + 1;
      exp_cnt4 = (exp_cnt4 == 15)    ? 15    : exp_cnt4 + 1;
      if (byp(exp_f.s1)) exp_f.rn = rwb;
      if (byp(exp_f.s2)) exp_f.rm = rwb;
    end else begin
      exp_f = in_f;
      if (byp(in_f.s1)) exp_f.rn = rwb;
      if (byp(in_f.s2)) exp_f.rm = rwb;
    end
  endtask

  task automatic tick(input string name);
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all(name);
  endtask

  function automatic fields_t rnd_in();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return fields_t'(t[158:0]);
  endfunction

  function automatic fields_t mkin(input logic v, input logic [31:0] pc, rn, rm,
                                   input logic [3:0] s1, s2, d, cmd, input logic [5:0] ctl);
    fields_t f;
    f = '{valid: v, pc: pc, rn: rn, rm: rm, s1: s1, s2: s2, d: d, cmd: cmd,
          mr: ctl[5], mw: ctl[4], wb: ctl[3], b: ctl[2], s: ctl[1], imm: ctl[0],
          sh: 12'hABC, off: 24'h123456, st: 4'h9};
    return f;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[7];
    vt[0] = '{mkin(1, 32'h10, 32'hA5A5_0001, 32'h2, 4'd1, 4'd2, 4'd4, 4'b0010, 6'b001000),
              1'b0, 4'd0, 32'h0, 32'hA5A5_0001, 32'h2};
    vt[1] = '{mkin(1, 32'h14, 32'h1, 32'h7, 4'd3, 4'd6, 4'd3, 4'd4, 6'b101000),
              1'b1, 4'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h7};
    vt[2] = '{mkin(1, 32'h18, 32'h1, 32'h7, 4'd15, 4'd6, 4'd3, 4'd4, 6'b001000),
              1'b1, 4'd15, 32'hDEAD_BEEF, 32'h1, 32'h7};
    vt[3] = '{mkin(1, 32'h1C, 32'h11, 32'h22, 4'd9, 4'd9, 4'd1, 4'd6, 6'b010001),
              1'b1, 4'd9, 32'hCAFE, 32'hCAFE, 32'hCAFE};
    vt[4] = '{mkin(1, 32'h20, 32'h33, 32'h44, 4'd4, 4'd5, 4'd2, 4'd1, 6'b000110),
              1'b0, 4'd4, 32'hBAD0, 32'h33, 32'h44};
    vt[5] = '{mkin(1, 32'h24, 32'h55, 32'h66, 4'd1, 4'd8, 4'd8, 4'd9, 6'b001010),
              1'b1, 4'd8, 32'h1234_5678, 32'h55, 32'h1234_5678};
    vt[6] = '{mkin(0, 32'h28, 32'h77, 32'h88, 4'd0, 4'd0, 4'd0, 4'd0, 6'b000000),
              1'b1, 4'd15, 32'hFFFF_FFFF, 32'h77, 32'h88};

    // Reset state with nonzero inputs applied
    in_f = rnd_in();
    wbe = 1'b1; dwb = 4'd3; rwb = 32'hFFFF_0000;
    @(negedge clk);
    @(negedge clk);
    compare_all("reset_state");

    rst = 1'b1;
    freeze = 1'b0;
    tick("first_load");
    freeze = 1'b1;
    tick("pre_rst_freeze0");
    tick("pre_rst_freeze1");

    // Asynchronous reset mid-cycle while frozen
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    exp_f = '0; exp_cnt = 0; exp_cnt4 = 0;
    compare_all("rst_async");
    @(negedge clk);
    rst = 1'b1;
    freeze = 1'b0;
    wbe = 1'b0;
    in_f = rnd_in();
    tick("post_rst_load");

    // Directed load vectors
    for (int unsigned i = 0; i < 7; i++) begin
      in_f = vt[i].in; wbe = vt[i].wbe; dwb = vt[i].dwb; rwb = vt[i].rwb;
      @(posedge clk);
      @(negedge clk);
      exp_f = vt[i].in;
      exp_f.rn = vt[i].exp_rn;
      exp_f.rm = vt[i].exp_rm;
      compare_all($sformatf("vec%0d", i));
    end

    // Freeze with held-entry bypass on src2
    in_f = mkin(1, 32'h40, 32'h100, 32'h200, 4'd2, 4'd5, 4'd6, 4'd3, 6'b001000);
    wbe = 1'b0;
    tick("frz_load");
    freeze = 1'b1;
    in_f = rnd_in();
    tick("frz_c1");
    wbe = 1'b1; dwb = 4'd5; rwb = 32'h55;
    tick("frz_c2");
    chk("frz_rm_bypass", 192'(val_rm_out), 192'(32'h55));
    wbe = 1'b0;
    tick("frz_c3");
    chk("frz_rm_hold", 192'(val_rm_out), 192'(32'h55));
    chk("frz_rn_hold", 192'(val_rn_out), 192'(32'h100));
    chk("frz_cnt3", 192'(stall_cnt), 192'(16'd3));

    // Flush wins over freeze; counter unchanged
    freeze = 1'b0;
    in_f = mkin(1, 32'h50, 32'h1, 32'h2, 4'd1, 4'd2, 4'd3, 4'd4, 6'b111111);
    tick("fl_load");
    freeze = 1'b1; flush = 1'b1;
    tick("fl_both");
    chk("fl_valid", 192'(valid_out), 192'(1'b0));
    chk("fl_wb_en", 192'(wb_en_out), 192'(1'b0));
    chk("fl_mem_w", 192'(mem_w_en_out), 192'(1'b0));
    chk("fl_cnt", 192'(stall_cnt), 192'(16'd3));
    flush = 1'b0;

    // Saturation of the 4-bit counter
    for (int unsigned i = 0; i < 20; i++) tick("sat");
    chk("sat_cnt4", 192'(cnt4), 192'(4'hF));
    tick("sat_more0");
    tick("sat_more1");
    chk("sat_cnt4_stay", 192'(cnt4), 192'(4'hF));
    chk("sat_cnt16", 192'(stall_cnt), 192'(16'd25));
    freeze = 1'b0;

    // Randomized traffic against the model
    for (int unsigned i = 0; i < 400; i++) begin
      in_f   = rnd_in();
      freeze = ($urandom_range(3) == 0);
      flush  = ($urandom_range(7) == 0);
      wbe    = $urandom_range(1);
      case ($urandom_range(3))
        0: dwb = in_f.s1;
        1: dwb = exp_f.s2;
        2: dwb = 4'd15;
        default: dwb = 4'($urandom_range(15));
      endcase
      rwb = $urandom();
      tick($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
